mux_seq_n: RTL and testbench
============================

Name: mux_seq_n

Overview:
- Parametrised, registered N:1 word selector with valid/ready handshake on both sides.
- Generalises the 16-bit 2:1 operand mux used in the memory-to-memory datapath to any width and any channel count.
- Direct mode: emits one selected word per transaction.
- Sweep mode: captures a whole vector of lanes in one transaction and serialises it, one element per handshake. Feeds the memory write path from the vector ALU outputs.

Parameters:
- WIDTH, 16, bits per lane/word.
- CHANNELS, 4, number of input lanes (>=2; need not be a power of 2).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= CHANNELS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- d  input  CHANNELS*WIDTH  flattened lanes; lane k = d[k*WIDTH +: WIDTH].
- s  input  SEL_W  lane select (direct) / start lane (sweep).
- mode  input  1  0 = direct, 1 = sweep; sampled on accept.
- in_valid  input  1  upstream has d/s/mode valid.
- in_ready  output  1  block can accept; accept = in_valid & in_ready.
- r  output  WIDTH  registered output word.
- out_valid  output  1  r is valid.
- out_ready  input  1  downstream takes r; beat = out_valid & out_ready.
- last  output  1  r is the final word of the current transaction.
- lane  output  SEL_W  lane index r was taken from.

Behaviour:
- Reset (async, while high): state IDLE; r=0, out_valid=0, last=0, lane=0, internal buffer=0, in_ready=0. After release: in_ready=1.
- FSM states: IDLE, HOLD, SWEEP.
- in_ready (combinational):
  - IDLE: 1.
  - HOLD: equals out_ready.
  - SWEEP: equals out_ready & last.
  - Forced 0 during reset.
- Accept with mode=0 (direct), s < CHANNELS:
  - Next edge: r = lane s, lane = s, last = 1, out_valid = 1; go to HOLD.
  - Latency is 1 cycle from accept to out_valid.
- Accept with mode=1 (sweep), s < CHANNELS:
  - Capture all of d into the internal buffer; next edge: r = buffer lane s, lane = s, out_valid = 1, last = (s == CHANNELS-1); go to SWEEP.
- SWEEP, beat with last=0: next edge lane+1, r = buffer[lane+1], last = (lane+1 == CHANNELS-1). Ascending order, no wrap-around.
- SWEEP or HOLD, beat with last=1:
  - With a simultaneous accept: load the new transaction (zero-bubble back-to-back).
  - Otherwise: out_valid=0, last=0, go to IDLE. r and lane keep their last values.
- Stall: out_valid=1 & out_ready=0 holds r, lane and last stable indefinitely. Input d may change freely after accept.
- Out-of-range s (s >= CHANNELS), either mode: a single beat with r=0, lane=s, last=1; FSM behaves as direct (HOLD).
- Reset mid-SWEEP or mid-HOLD: the transaction is abandoned immediately, with no further beats after release.
- The d/s/mode path is registered; no combinational path from d to r.

Optional Feature:
- Macro: MUX_SEQ_PARITY_EN.
- Defined: adds output port par (1 bit), registered alongside r. par = even parity (XOR-reduce) of the word loaded into r; reset 0; forced 0 for out-of-range beats.
- Not defined: port par is absent and no parity logic is built. All other behaviour is identical.

Test Plan:
Parameters: WIDTH=16, CHANNELS=4; d lanes 0..3 = 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD.
1. Reset then idle -> r=16'h0000, out_valid=0, last=0, lane=0; in_ready=0 during reset and 1 the cycle after release.
2. Direct accept, s=2, out_ready=1 -> one cycle later r=16'hCCCC, lane=2, last=1, out_valid=1 for exactly one cycle. A back-to-back accept with s=1 in that cycle gives r=16'hBBBB the next cycle with no bubble.
3. Sweep accept, s=1; d changed to all 16'hFFFF right after accept; out_ready held 1 -> beats 16'hBBBB, 16'hCCCC, 16'hDDDD on lanes 1, 2, 3; last=1 only on 16'hDDDD; in_ready=0 until that beat.
4. Sweep, s=0, out_ready toggled 1,0,0,1,... -> r stable during stalls; exactly 4 beats AAAA, BBBB, CCCC, DDDD.
5. CHANNELS=3, s=3, either mode -> single beat r=16'h0000, lane=3, last=1. Reset asserted during a sweep at lane 1 -> out_valid=0 immediately; no beats after release.
6. With MUX_SEQ_PARITY_EN defined: direct select of 16'h0001 -> par=1; select of 16'hAAAA -> par=0.

Source files
------------

// File: rtl/mux_seq_n.sv
// mux_seq_n: registered N:1 word selector with valid/ready on both sides.
//   mode=0 (direct): one selected lane per transaction.
//   mode=1 (sweep) : capture every lane, then emit lanes s..CHANNELS-1 in
//                    ascending order, one word per output beat.
// A select at or above CHANNELS gives a single zero word with last=1.
// Optional build macro MUX_SEQ_PARITY_EN adds the registered even-parity
// output 'par' alongside r.
//
// Handshake: an input transfer (accept) happens on a rising edge where
// in_valid & in_ready. An output transfer (beat) happens on a rising edge
// where out_valid & out_ready. While out_valid=1 and out_ready=0, the
// outputs r/lane/last (and par) stay frozen.
module mux_seq_n #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] d,
   input  logic [SEL_W-1:0]          s,
   input  logic                      mode,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [WIDTH-1:0]          r,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      last,
   output logic [SEL_W-1:0]          lane,
`ifdef MUX_SEQ_PARITY_EN
   output logic                      par,
`endif
   output logic [1:0]                state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      SWEEP = 2'd2
   } state_t;

   localparam logic [SEL_W:0]   CH_EXT    = (SEL_W+1)'(CHANNELS);
   localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(CHANNELS - 1);

   state_t                    state;
   logic [CHANNELS*WIDTH-1:0] buf_q;

   logic                      accept;
   logic                      beat;
   logic                      s_in_range;
   logic [WIDTH-1:0]          load_word;
   logic [SEL_W-1:0]          next_lane;
   logic [WIDTH-1:0]          sweep_word;

   // Lane extraction that never indexes past the last real lane.
   function automatic logic [WIDTH-1:0] pick(
      input logic [CHANNELS*WIDTH-1:0] vec,
      input logic [SEL_W-1:0]          idx
   );
      logic [WIDTH-1:0] res;
      res = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (idx == SEL_W'(k)) res = vec[k*WIDTH +: WIDTH];
      end
      return res;
   endfunction

   assign state_dbg  = state;
   assign accept     = in_valid & in_ready;
   assign beat       = out_valid & out_ready;
   assign s_in_range = ({1'b0, s} < CH_EXT);
   assign load_word  = s_in_range ? pick(d, s) : '0;
   assign next_lane  = lane + 1'b1;
   assign sweep_word = pick(buf_q, next_lane);

   // Upstream may load only when the current output word is the final one
   // and is leaving this cycle (or nothing is pending at all).
   always_comb begin
      in_ready = 1'b0;
      if (!reset) begin
         case (state)
            IDLE:    in_ready = 1'b1;
            HOLD:    in_ready = out_ready;
            SWEEP:   in_ready = out_ready & last;
            default: in_ready = 1'b0;
         endcase
      end
   end

   // Transaction FSM plus all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         r         <= '0;
         out_valid <= 1'b0;
         last      <= 1'b0;
         lane      <= '0;
         buf_q     <= '0;
`ifdef MUX_SEQ_PARITY_EN
         par       <= 1'b0;
`endif
      end else if (accept) begin
         // New transaction; also covers the final beat of the previous one.
         r         <= load_word;
         lane      <= s;
         out_valid <= 1'b1;
`ifdef MUX_SEQ_PARITY_EN
         par       <= ^load_word;
`endif
         if (mode && s_in_range) begin
            buf_q <= d;
            last  <= (s == LAST_LANE);
            state <= SWEEP;
         end else begin
            last  <= 1'b1;
            state <= HOLD;
         end
      end else if (beat) begin
         if (last) begin
            // r and lane deliberately keep their final values.
            out_valid <= 1'b0;
            last      <= 1'b0;
            state     <= IDLE;
         end else begin
            lane <= next_lane;
            r    <= sweep_word;
            last <= (next_lane == LAST_LANE);
`ifdef MUX_SEQ_PARITY_EN
            par  <= ^sweep_word;
`endif
         end
      end
   end

endmodule

// File: tb/tb_mux_seq_n.sv
// tb_mux_seq_n: bench for mux_seq_n. A 4-lane instance is checked every
// cycle against a queue of expected output beats built from the transaction
// rules; a 3-lane instance covers out-of-range selects. Directed sequences
// pin the model with literal expectations, then random traffic follows.
module tb_mux_seq_n;

   localparam int W  = 16;
   localparam int CH = 4;
   localparam int EW = W + 2 + 1;   // {last, lane, word}

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- 4-lane DUT ----------------
   logic [CH*W-1:0] d;
   logic [1:0]      s;
   logic            mode, in_valid, in_ready, out_valid, out_ready, last;
   logic [W-1:0]    r;
   logic [1:0]      lane, state_dbg;
`ifdef MUX_SEQ_PARITY_EN
   logic            par;
`endif

   mux_seq_n #(.WIDTH(W), .CHANNELS(CH), .SEL_W(2)) dut (
      .clk(clk), .reset(reset), .d(d), .s(s), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready), .r(r),
      .out_valid(out_valid), .out_ready(out_ready), .last(last), .lane(lane),
`ifdef MUX_SEQ_PARITY_EN
      .par(par),
`endif
      .state_dbg(state_dbg)
   );

   // ---------------- 3-lane DUT ----------------
   logic [3*W-1:0] d3;
   logic [1:0]     s3;
   logic           mode3, in_valid3, in_ready3, out_valid3, out_ready3, last3;
   logic [W-1:0]   r3;
   logic [1:0]     lane3, state_dbg3;
`ifdef MUX_SEQ_PARITY_EN
   logic           par3;
`endif

   mux_seq_n #(.WIDTH(W), .CHANNELS(3), .SEL_W(2)) dut3 (
      .clk(clk), .reset(reset), .d(d3), .s(s3), .mode(mode3),
      .in_valid(in_valid3), .in_ready(in_ready3), .r(r3),
      .out_valid(out_valid3), .out_ready(out_ready3), .last(last3), .lane(lane3),
`ifdef MUX_SEQ_PARITY_EN
      .par(par3),
`endif
      .state_dbg(state_dbg3)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   logic [EW-1:0] exp_q[$];
   logic [W-1:0]  mdl_r;
   logic [1:0]    mdl_lane;

   // Every output word a transaction must produce, in order.
   task automatic push_txn(input logic [CH*W-1:0] dv, input logic [1:0] sv, input logic mv);
      if (int'(sv) >= CH) begin
         exp_q.push_back({1'b1, sv, 16'h0000});
      end else if (!mv) begin
         exp_q.push_back({1'b1, sv, dv[int'(sv)*W +: W]});
      end else begin
         for (int i = int'(sv); i < CH; i++)
            exp_q.push_back({(i == CH - 1), 2'(i), dv[i*W +: W]});
      end
   endtask

   function automatic logic mdl_in_ready();
      if (exp_q.size() == 0) return 1'b1;
      if (exp_q.size() == 1) return out_ready;
      return 1'b0;
   endfunction

   // Model advance: decisions use only bench-driven inputs and model state.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q.delete();
         mdl_r    = '0;
         mdl_lane = '0;
      end else begin
         logic acc;
         logic [EW-1:0] f;
         acc = in_valid && mdl_in_ready();
         if (exp_q.size() != 0 && out_ready) begin
            f        = exp_q.pop_front();
            mdl_r    = f[W-1:0];
            mdl_lane = f[W+1:W];
         end
         if (acc) push_txn(d, s, mode);
      end
   end

   // Per-cycle comparison on the falling edge.
   always @(negedge clk) begin
      logic [EW-1:0] f;
      if (reset) begin
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_in_ready",  32'(in_ready),  32'd0);
         chk("rst_r",         32'(r),         32'd0);
         chk("rst_last",      32'(last),      32'd0);
         chk("rst_lane",      32'(lane),      32'd0);
      end else begin
         chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
         chk("in_ready",  32'(in_ready),  32'(mdl_in_ready()));
         if (exp_q.size() != 0) begin
            f = exp_q[0];
            chk("r",    32'(r),    32'(f[W-1:0]));
            chk("lane", 32'(lane), 32'(f[W+1:W]));
            chk("last", 32'(last), 32'(f[W+2]));
`ifdef MUX_SEQ_PARITY_EN
            chk("par",  32'(par),  32'(^f[W-1:0]));
`endif
         end else begin
            chk("idle_r",    32'(r),    32'(mdl_r));
            chk("idle_lane", 32'(lane), 32'(mdl_lane));
            chk("idle_last", 32'(last), 32'd0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [CH*W-1:0] D_STD = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};

   task automatic send(input logic [1:0] sv, input logic mv);
      d = D_STD; s = sv; mode = mv; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   logic [W-1:0] seen[4];
   logic [W-1:0] want[4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

   initial begin
      int beats;
      logic prev_stall;
      logic [W-1:0] prev_r;

      reset = 1'b1;
      d = '0; s = '0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      d3 = {16'hCCCC, 16'hBBBB, 16'hAAAA};
      s3 = '0; mode3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b1;

      // 1: reset values, then ready one cycle after release
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("t1_in_ready_rst", 32'(in_ready), 32'd0);
      chk("t1_r_rst", 32'(r), 32'h0);
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("t1_in_ready_rel", 32'(in_ready), 32'd1);
      chk("t1_out_valid", 32'(out_valid), 32'd0);

      // 2: direct s=2, then back-to-back s=1
      d = D_STD; s = 2'd2; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      step();
      s = 2'd1;
      @(negedge clk);
      chk("t2_r", 32'(r), 32'hCCCC);
      chk("t2_lane", 32'(lane), 32'd2);
      chk("t2_last", 32'(last), 32'd1);
      chk("t2_valid", 32'(out_valid), 32'd1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t2_b2b_r", 32'(r), 32'hBBBB);
      chk("t2_b2b_valid", 32'(out_valid), 32'd1);
      step();
      @(negedge clk);
      chk("t2_done_valid", 32'(out_valid), 32'd0);
      chk("t2_hold_r", 32'(r), 32'hBBBB);

      // 3: sweep s=1, d trashed after accept
      send(2'd1, 1'b1);
      d = {4{16'hFFFF}};
      @(negedge clk);
      chk("t3_r0", 32'(r), 32'hBBBB);
      chk("t3_last0", 32'(last), 32'd0);
      chk("t3_rdy0", 32'(in_ready), 32'd0);
      step();
      @(negedge clk);
      chk("t3_r1", 32'(r), 32'hCCCC);
      chk("t3_lane1", 32'(lane), 32'd2);
      chk("t3_rdy1", 32'(in_ready), 32'd0);
      step();
      @(negedge clk);
      chk("t3_r2", 32'(r), 32'hDDDD);
      chk("t3_lane2", 32'(lane), 32'd3);
      chk("t3_last2", 32'(last), 32'd1);
      chk("t3_rdy2", 32'(in_ready), 32'd1);
      step();
      @(negedge clk);
      chk("t3_done", 32'(out_valid), 32'd0);

      // 4: sweep s=0 with out_ready pattern 1,0,0,1
      send(2'd0, 1'b1);
      beats = 0; prev_stall = 1'b0; prev_r = '0;
      for (int c = 0; c < 20; c++) begin
         out_ready = pat[c % 4];
         @(negedge clk);
         if (prev_stall) chk("t4_stall_r", 32'(r), 32'(prev_r));
         if (out_valid && out_ready) begin
            if (beats < 4) seen[beats] = r;
            beats++;
         end
         prev_stall = out_valid && !out_ready;
         prev_r = r;
         step();
      end
      chk("t4_beats", 32'(beats), 32'd4);
      for (int i = 0; i < 4; i++) chk("t4_word", 32'(seen[i]), 32'(want[i]));
      out_ready = 1'b1;

      // 5a: out-of-range selects on the 3-lane instance
      for (int m = 0; m < 2; m++) begin
         s3 = 2'd3; mode3 = m[0]; in_valid3 = 1'b1;
         step();
         in_valid3 = 1'b0;
         @(negedge clk);
         chk("t5_oor_r", 32'(r3), 32'h0);
         chk("t5_oor_lane", 32'(lane3), 32'd3);
         chk("t5_oor_last", 32'(last3), 32'd1);
         chk("t5_oor_valid", 32'(out_valid3), 32'd1);
`ifdef MUX_SEQ_PARITY_EN
         chk("t5_oor_par", 32'(par3), 32'd0);
`endif
         step();
         @(negedge clk);
         chk("t5_oor_single", 32'(out_valid3), 32'd0);
      end
      // 3-lane sweep ends on lane 2
      s3 = 2'd1; mode3 = 1'b1; in_valid3 = 1'b1;
      step();
      in_valid3 = 1'b0;
      @(negedge clk);
      chk("t5_sw_r0", 32'(r3), 32'hBBBB);
      chk("t5_sw_last0", 32'(last3), 32'd0);
      step();
      @(negedge clk);
      chk("t5_sw_r1", 32'(r3), 32'hCCCC);
      chk("t5_sw_last1", 32'(last3), 32'd1);
      step();
      @(negedge clk);
      chk("t5_sw_done", 32'(out_valid3), 32'd0);

      // 5b: reset during a sweep at lane 1
      send(2'd0, 1'b1);
      @(negedge clk);
      chk("t5_rst_lane0", 32'(lane), 32'd0);
      step();
      @(negedge clk);
      chk("t5_rst_lane1", 32'(lane), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("t5_rst_valid", 32'(out_valid), 32'd0);
      chk("t5_rst_rdy", 32'(in_ready), 32'd0);
      step();
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("t5_no_beats", 32'(out_valid), 32'd0);
      end

`ifdef MUX_SEQ_PARITY_EN
      // 6: parity literals
      d = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'h0001}; s = 2'd0; mode = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t6_par_0001", 32'(par), 32'd1);
      step();
      send(2'd0, 1'b0);
      @(negedge clk);
      chk("t6_par_aaaa", 32'(par), 32'd0);
      step();
`endif

      // random traffic, checked by the per-cycle compare
      for (int c = 0; c < 3000; c++) begin
         d         = {$urandom, $urandom};
         s         = 2'($urandom_range(0, 3));
         mode      = 1'($urandom_range(0, 1));
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      // drain with a bounded wait
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!out_valid) break;
      end
      chk("drain", 32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
